// File: rtl/event_interval_monitor.sv
// event_interval_monitor: measures cycles between synchronised start/end rises and keeps min/max/error statistics
module event_interval_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_CYCLES  = 4,
    parameter int MAX_CYCLES  = 20,
    parameter int CNT_WIDTH   = 8,
    parameter int ERR_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear_stats,
    input  logic                 start_event,
    input  logic                 end_event,
    output logic                 busy,
    output logic                 measure_valid,
    output logic [CNT_WIDTH-1:0] measured_cycles,
    output logic                 too_short,
    output logic                 too_long,
    output logic [ERR_WIDTH-1:0] error_count,
    output logic [CNT_WIDTH-1:0] min_seen,
    output logic [CNT_WIDTH-1:0] max_seen
);
    typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;

    localparam logic [CNT_WIDTH-1:0] MIN_C = CNT_WIDTH'(MIN_CYCLES);
    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_CYCLES);
    localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    logic [SYNC_STAGES:0]  start_sync_q, end_sync_q;
    logic                  start_rise, end_rise;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, meas_q, meas_d, min_q, max_q;
    logic                  mv_q, mv_d, short_q, short_d, long_q, long_d;
    logic [ERR_WIDTH-1:0]  err_q;

    // The top bit of each chain is the edge history; all ones at reset so a held-high level is not an edge
    always_ff @(posedge clock) begin
        if (reset) begin
            start_sync_q <= '1;
            end_sync_q   <= '1;
        end else begin
            start_sync_q <= {start_sync_q[SYNC_STAGES-1:0], start_event};
            end_sync_q   <= {end_sync_q[SYNC_STAGES-1:0], end_event};
        end
    end

    assign start_rise = enable & start_sync_q[SYNC_STAGES-1] & ~start_sync_q[SYNC_STAGES];
    assign end_rise   = enable & end_sync_q[SYNC_STAGES-1] & ~end_sync_q[SYNC_STAGES];

    // Interval FSM: next state, counter and pulse decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        meas_d  = meas_q;
        mv_d    = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        state_d = MEASURE;
                        cnt_d   = ONE_C;
                    end
                end
                MEASURE: begin
                    if (end_rise) begin
                        meas_d  = cnt_q;
                        mv_d    = 1'b1;
                        short_d = cnt_q < MIN_C;
                        state_d = start_rise ? MEASURE : IDLE;
                        cnt_d   = start_rise ? ONE_C : cnt_q;
                    end else if (start_rise) begin
                        cnt_d = ONE_C;
                    end else if (cnt_q == MAX_C) begin
                        long_d  = 1'b1;
                        state_d = TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                TIMEOUT: state_d = end_rise ? IDLE : TIMEOUT;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counter and registered measurement outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            meas_q  <= '0;
            mv_q    <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
            mv_q    <= mv_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

    // Statistics; a clear overrides any update landing in the same cycle
    always_ff @(posedge clock) begin
        if (reset || clear_stats) begin
            err_q <= '0;
            min_q <= '1;
            max_q <= '0;
        end else begin
            if ((short_d || long_d) && err_q != '1) err_q <= err_q + ERR_WIDTH'(1);
            if (mv_d && cnt_q < min_q) min_q <= cnt_q;
            if (mv_d && cnt_q > max_q) max_q <= cnt_q;
        end
    end

    assign busy            = state_q != IDLE;
    assign measure_valid   = mv_q;
    assign measured_cycles = meas_q;
    assign too_short       = short_q;
    assign too_long        = long_q;
    assign error_count     = err_q;
    assign min_seen        = min_q;
    assign max_seen        = max_q;
endmodule

// File: tb/tb_event_interval_monitor.sv
// tb_event_interval_monitor: directed and random stimulus against a timestamp-based reference model
module tb_event_interval_monitor;
    localparam int S    = 2;
    localparam int MINC = 4;
    localparam int MAXC = 20;

    logic       clock = 1'b0, reset = 1'b1, enable = 1'b0, clear_stats = 1'b0;
    logic       start_event = 1'b0, end_event = 1'b0;
    logic       busy, measure_valid, too_short, too_long;
    logic [7:0] measured_cycles, error_count, min_seen, max_seen;

    int checks = 0, failures = 0;

    int mode = 0, cyc = 0, t0 = 0;
    int e_meas = 0, e_err = 0, e_min = 255, e_max = 0;
    bit e_mv = 0, e_sh = 0, e_lg = 0;
    bit sq_s[$], sq_e[$];

    event_interval_monitor dut (
        .clock(clock), .reset(reset), .enable(enable), .clear_stats(clear_stats),
        .start_event(start_event), .end_event(end_event), .busy(busy),
        .measure_valid(measure_valid), .measured_cycles(measured_cycles),
        .too_short(too_short), .too_long(too_long), .error_count(error_count),
        .min_seen(min_seen), .max_seen(max_seen)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input bit s, input bit e, input bit en, input bit clr, input bit rst);
        bit sr, er;
        int len;
        @(negedge clock);
        start_event = s; end_event = e; enable = en; clear_stats = clr; reset = rst;
        e_mv = 0; e_sh = 0; e_lg = 0;
        if (rst) begin
            mode = 0; e_meas = 0; e_err = 0; e_min = 255; e_max = 0;
            sq_s = {}; sq_e = {};
            for (int i = 0; i <= S; i++) begin
                sq_s.push_back(1'b1);
                sq_e.push_back(1'b1);
            end
        end else begin
            sr = en && sq_s[$-(S-1)] && !sq_s[$-S];
            er = en && sq_e[$-(S-1)] && !sq_e[$-S];
            if (!en) mode = 0;
            else if (mode == 0) begin
                if (sr) begin mode = 1; t0 = cyc; end
            end else if (mode == 1) begin
                len = cyc - t0;
                if (er) begin
                    e_mv = 1; e_meas = len; e_sh = len < MINC;
                    if (len < e_min) e_min = len;
                    if (len > e_max) e_max = len;
                    if (sr) t0 = cyc; else mode = 0;
                end else if (sr) t0 = cyc;
                else if (len == MAXC) begin e_lg = 1; mode = 2; end
            end else if (er) mode = 0;
            if ((e_sh || e_lg) && e_err < 255) e_err++;
            if (clr) begin e_err = 0; e_min = 255; e_max = 0; end
            sq_s.push_back(s); sq_e.push_back(e);
            void'(sq_s.pop_front()); void'(sq_e.pop_front());
        end
        cyc++;
        @(posedge clock);
        #1;
        check("busy", busy, mode != 0);
        check("measure_valid", measure_valid, e_mv);
        check("measured_cycles", measured_cycles, e_meas);
        check("too_short", too_short, e_sh);
        check("too_long", too_long, e_lg);
        check("error_count", error_count, e_err);
        check("min_seen", min_seen, e_min);
        check("max_seen", max_seen, e_max);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0);
    endtask

    // Start pulse, end pulse 'gap' drive steps later, then let detection settle
    task automatic interval(input int gap);
        step(1, 0, 1, 0, 0);
        idle(gap - 1);
        step(0, 1, 1, 0, 0);
        idle(S + 2);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        check("reset_min_seen", min_seen, 255);
        check("reset_busy", busy, 0);
        idle(4);

        interval(10);
        check("t1_measured", measured_cycles, 10);
        check("t1_min", min_seen, 10);
        check("t1_max", max_seen, 10);
        check("t1_err", error_count, 0);

        interval(2);
        check("t2_measured", measured_cycles, 2);
        check("t2_min", min_seen, 2);
        check("t2_err", error_count, 1);

        step(1, 0, 1, 0, 0);
        idle(30);
        check("t3_busy_timeout", busy, 1);
        check("t3_err", error_count, 2);
        step(0, 1, 1, 0, 0);
        idle(S + 2);
        check("t3_idle", busy, 0);
        check("t3_measured_held", measured_cycles, 2);

        step(1, 0, 1, 0, 0);
        idle(4);
        interval(6);
        check("t4_restart", measured_cycles, 6);
        step(1, 0, 1, 0, 0);
        idle(7);
        step(1, 1, 1, 0, 0);
        idle(S + 2);
        check("t4_b2b_measured", measured_cycles, 8);
        check("t4_b2b_busy", busy, 1);
        step(0, 1, 1, 0, 0);
        idle(S + 2);

        for (int i = 0; i < 300; i++) interval(2);
        check("t5_saturate", error_count, 255);
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        check("t5_clear_pulse", too_short, 1);
        check("t5_clear_err", error_count, 0);
        idle(4);

        step(1, 0, 1, 0, 0);
        idle(S + 7);
        step(1, 0, 1, 0, 1);
        check("t6_busy", busy, 0);
        check("t6_mv", measure_valid, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0);
        check("t6_held_high", busy, 0);
        idle(4);

        for (int b = 0; b < 3; b++) begin
            int ps, pe;
            ps = (b == 0) ? 6 : (b == 1) ? 12 : 3;
            pe = (b == 0) ? 4 : (b == 1) ? 30 : 3;
            for (int i = 0; i < 1500; i++)
                step($urandom_range(0, ps) == 0, $urandom_range(0, pe) == 0,
                     $urandom_range(0, 30) != 0, $urandom_range(0, 100) == 0,
                     $urandom_range(0, 500) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
